// File: rtl/operand_fetch_if.sv
// Bundle of operand-fetch signals between the address calculator, the
// memory buses and the execute stage.
interface operand_fetch_if #(
  parameter int unsigned W = 16
);
  logic [2:0]   AdAs;
  logic         CALC_done;
  logic [W-1:0] CALC_out;
  logic [W-1:0] MDB_out;
  logic [W-1:0] MAB_out;
  logic         MEM_rd;
  logic [W-1:0] SRC_op;
  logic [W-1:0] DST_op;
  logic [W-1:0] DST_addr;
  logic         OP_valid;
  logic         busy;
  logic         ovr;

  // Upstream/environment side: supplies mode, addresses and read data.
  modport master (
    output AdAs, CALC_done, CALC_out, MDB_out,
    input  MAB_out, MEM_rd, SRC_op, DST_op, DST_addr, OP_valid, busy, ovr
  );

  // Operand fetch stage side.
  modport slave (
    input  AdAs, CALC_done, CALC_out, MDB_out,
    output MAB_out, MEM_rd, SRC_op, DST_op, DST_addr, OP_valid, busy, ovr
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: captures effective addresses from the indexed-mode
// calculator, reads source/destination operands over MAB/MDB and hands
// them to execute with a single OP_valid pulse.
module operand_fetch #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  operand_fetch_if.slave bus
);

  localparam logic [2:0] LatInit = 3'(MEM_LAT);

  typedef enum logic [2:0] {
    Idle,
    SReq,
    SWait,
    DReq,
    DWait,
    Done
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic [W-1:0] mab_q, mab;
  logic         mem_rd;
  logic         op_valid;
  logic         src_load, dst_load;

  logic [1:0]   n_q, n_d, n_eff, need;
  logic [W-1:0] src_addr_q, dst_addr_q;
  logic [W-1:0] src_op_q, dst_op_q;
  logic         ovr_q;

  logic         mode_src, mode_dst, mode_dual, mode_ok;
  logic         accept, drop, first_acc, second_acc, have_dst;

  // Decode addressing mode and classify each CALC_done pulse.
  always_comb begin
    mode_src   = (bus.AdAs == 3'b001);
    mode_dst   = (bus.AdAs == 3'b100);
    mode_dual  = (bus.AdAs == 3'b101);
    mode_ok    = mode_src | mode_dst | mode_dual;
    // The DONE cycle already belongs to the next operation for capture.
    n_eff      = (state_q == Done) ? 2'd0 : n_q;
    need       = mode_dual ? 2'd2 : 2'd1;
    accept     = bus.CALC_done && mode_ok && (n_eff < need);
    drop       = bus.CALC_done && mode_ok && (n_eff >= need);
    first_acc  = accept && (n_eff == 2'd0);
    second_acc = accept && (n_eff == 2'd1);
    // A second address arriving this very cycle is usable next cycle.
    have_dst   = (n_q == 2'd2) || second_acc;
    n_d        = accept ? (n_eff + 2'd1) : n_eff;
  end

  // Next-state, counter and bus-drive logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    mem_rd   = 1'b0;
    op_valid = 1'b0;
    mab      = mab_q;
    src_load = 1'b0;
    dst_load = 1'b0;
    unique case (state_q)
      Idle: begin
        if (accept) begin
          state_d = bus.AdAs[0] ? SReq : DReq;
          busy_d  = 1'b1;
        end
      end
      SReq: begin
        mem_rd  = 1'b1;
        mab     = src_addr_q;
        cnt_d   = LatInit;
        state_d = SWait;
      end
      SWait: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) src_load = 1'b1;
        end
        // Counter at 0 means the source is in and only the second
        // address is outstanding.
        if (cnt_q <= 3'd1) begin
          if (mode_dual) begin
            if (have_dst) state_d = DReq;
          end else begin
            state_d = Done;
          end
        end
      end
      DReq: begin
        mem_rd  = 1'b1;
        mab     = dst_addr_q;
        cnt_d   = LatInit;
        state_d = DWait;
      end
      DWait: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          dst_load = 1'b1;
          state_d  = Done;
        end
      end
      Done: begin
        op_valid = 1'b1;
        if (accept) begin
          // Back-to-back operation: skip Idle, stay busy.
          state_d = bus.AdAs[0] ? SReq : DReq;
          busy_d  = 1'b1;
        end else begin
          state_d = Idle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = Idle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, latency counter, busy flag and held bus address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Idle;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      mab_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      mab_q   <= mab;
    end
  end

  // Address capture and sticky overrun, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q        <= 2'd0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      ovr_q      <= 1'b0;
    end else begin
      n_q <= n_d;
      if (first_acc) begin
        if (bus.AdAs[0]) src_addr_q <= bus.CALC_out;
        else             dst_addr_q <= bus.CALC_out;
      end
      if (second_acc) dst_addr_q <= bus.CALC_out;
      if (drop)       ovr_q      <= 1'b1;
    end
  end

  // Operand registers loaded from the memory data bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_op_q <= '0;
      dst_op_q <= '0;
    end else begin
      if (src_load) src_op_q <= bus.MDB_out;
      if (dst_load) dst_op_q <= bus.MDB_out;
    end
  end

  assign bus.MAB_out  = mab;
  assign bus.MEM_rd   = mem_rd;
  assign bus.SRC_op   = src_op_q;
  assign bus.DST_op   = dst_op_q;
  assign bus.DST_addr = dst_addr_q;
  assign bus.OP_valid = op_valid;
  assign bus.busy     = busy_q;
  assign bus.ovr      = ovr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: one instance with MEM_LAT=1 (b1) and one
// with MEM_LAT=3 (b3) share clock and reset. Inputs change #1 after posedge;
// outputs are checked at that same point, away from the edge.
module tb_operand_fetch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  operand_fetch_if #(.W(16)) b1 ();
  operand_fetch_if #(.W(16)) b3 ();

  operand_fetch #(.MEM_LAT(1), .W(16)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  operand_fetch #(.MEM_LAT(3), .W(16)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    b1.AdAs = 3'b000; b1.CALC_done = 1'b0; b1.CALC_out = '0; b1.MDB_out = '0;
    b3.AdAs = 3'b000; b3.CALC_done = 1'b0; b3.CALC_out = '0; b3.MDB_out = '0;
    #2;
    // Reset state
    chk("rst_mab", b1.MAB_out, 16'h0);
    chk("rst_memrd", 16'(b1.MEM_rd), 16'h0);
    chk("rst_src", b1.SRC_op, 16'h0);
    chk("rst_dstop", b1.DST_op, 16'h0);
    chk("rst_dstaddr", b1.DST_addr, 16'h0);
    chk("rst_opvalid", 16'(b1.OP_valid), 16'h0);
    chk("rst_busy", 16'(b1.busy), 16'h0);
    chk("rst_ovr", 16'(b1.ovr), 16'h0);
    step();
    step();
    rst = 1'b0;
    step();

    // Source fetch, MEM_LAT=1
    b1.AdAs = 3'b001; b1.CALC_out = 16'h0204; b1.CALC_done = 1'b1;   // t
    chk("src_busy_t", 16'(b1.busy), 16'h0);
    step();                                                          // t+1
    b1.CALC_done = 1'b0; b1.MDB_out = 16'hBEEF;
    chk("src_memrd_t1", 16'(b1.MEM_rd), 16'h1);
    chk("src_mab_t1", b1.MAB_out, 16'h0204);
    chk("src_busy_t1", 16'(b1.busy), 16'h1);
    chk("src_opv_t1", 16'(b1.OP_valid), 16'h0);
    step();                                                          // t+2
    chk("src_memrd_t2", 16'(b1.MEM_rd), 16'h0);
    chk("src_mabhold_t2", b1.MAB_out, 16'h0204);
    step();                                                          // t+3
    chk("src_opv_t3", 16'(b1.OP_valid), 16'h1);
    chk("src_op_t3", b1.SRC_op, 16'hBEEF);
    chk("src_busy_t3", 16'(b1.busy), 16'h1);
    step();                                                          // t+4
    chk("src_opv_t4", 16'(b1.OP_valid), 16'h0);
    chk("src_busy_t4", 16'(b1.busy), 16'h0);

    // Dual fetch, second pulse two cycles later
    b1.AdAs = 3'b101; b1.CALC_out = 16'h0300; b1.CALC_done = 1'b1;   // t
    step();                                                          // t+1
    b1.CALC_done = 1'b0; b1.MDB_out = 16'h1111;
    chk("dual_memrd_t1", 16'(b1.MEM_rd), 16'h1);
    chk("dual_mab_t1", b1.MAB_out, 16'h0300);
    step();                                                          // t+2
    b1.CALC_out = 16'h0410; b1.CALC_done = 1'b1;
    chk("dual_memrd_t2", 16'(b1.MEM_rd), 16'h0);
    step();                                                          // t+3
    b1.CALC_done = 1'b0; b1.MDB_out = 16'h2222;
    chk("dual_memrd_t3", 16'(b1.MEM_rd), 16'h1);
    chk("dual_mab_t3", b1.MAB_out, 16'h0410);
    chk("dual_src_t3", b1.SRC_op, 16'h1111);
    chk("dual_dstaddr_t3", b1.DST_addr, 16'h0410);
    step();                                                          // t+4
    chk("dual_opv_t4", 16'(b1.OP_valid), 16'h0);
    step();                                                          // t+5
    chk("dual_opv_t5", 16'(b1.OP_valid), 16'h1);
    chk("dual_dstop_t5", b1.DST_op, 16'h2222);
    chk("dual_src_t5", b1.SRC_op, 16'h1111);
    chk("dual_ovr_t5", 16'(b1.ovr), 16'h0);
    step();                                                          // t+6
    chk("dual_opv_t6", 16'(b1.OP_valid), 16'h0);
    chk("dual_busy_t6", 16'(b1.busy), 16'h0);

    // MEM_LAT=3: preload a source operand, then destination-only fetch
    b3.AdAs = 3'b001; b3.CALC_out = 16'h0100; b3.MDB_out = 16'h5A5A; b3.CALC_done = 1'b1;
    step();
    b3.CALC_done = 1'b0;
    step();
    step();
    step();
    step();                                                          // t+5
    chk("lat_pre_opv", 16'(b3.OP_valid), 16'h1);
    chk("lat_pre_src", b3.SRC_op, 16'h5A5A);
    step();
    b3.AdAs = 3'b100; b3.CALC_out = 16'h0FFE; b3.CALC_done = 1'b1;   // t
    b3.MDB_out = 16'h1111;
    step();                                                          // t+1
    b3.CALC_done = 1'b0;
    chk("lat_memrd_t1", 16'(b3.MEM_rd), 16'h1);
    chk("lat_mab_t1", b3.MAB_out, 16'h0FFE);
    chk("lat_dstaddr_t1", b3.DST_addr, 16'h0FFE);
    step();                                                          // t+2
    step();                                                          // t+3
    chk("lat_opv_t3", 16'(b3.OP_valid), 16'h0);
    step();                                                          // t+4
    b3.MDB_out = 16'h00A5;
    chk("lat_opv_t4", 16'(b3.OP_valid), 16'h0);
    step();                                                          // t+5
    b3.MDB_out = 16'hFFFF;
    chk("lat_opv_t5", 16'(b3.OP_valid), 16'h1);
    chk("lat_dstop_t5", b3.DST_op, 16'h00A5);
    chk("lat_src_kept", b3.SRC_op, 16'h5A5A);
    step();

    // Overrun: extra pulse while a source-only fetch is in flight
    b1.AdAs = 3'b001; b1.CALC_out = 16'h0600; b1.CALC_done = 1'b1;   // t
    step();                                                          // t+1
    b1.CALC_out = 16'h0500;
    chk("ovr_memrd_t1", 16'(b1.MEM_rd), 16'h1);
    chk("ovr_mab_t1", b1.MAB_out, 16'h0600);
    chk("ovr_flag_t1", 16'(b1.ovr), 16'h0);
    step();                                                          // t+2
    b1.CALC_done = 1'b0; b1.MDB_out = 16'h7777;
    chk("ovr_flag_t2", 16'(b1.ovr), 16'h1);
    chk("ovr_mab_t2", b1.MAB_out, 16'h0600);
    chk("ovr_memrd_t2", 16'(b1.MEM_rd), 16'h0);
    step();                                                          // t+3
    chk("ovr_opv_t3", 16'(b1.OP_valid), 16'h1);
    chk("ovr_src_t3", b1.SRC_op, 16'h7777);
    chk("ovr_mab_t3", b1.MAB_out, 16'h0600);
    step();                                                          // t+4
    chk("ovr_sticky_t4", 16'(b1.ovr), 16'h1);
    chk("ovr_busy_t4", 16'(b1.busy), 16'h0);
    step();
    chk("ovr_sticky_t5", 16'(b1.ovr), 16'h1);

    // Reset during S_WAIT
    b1.AdAs = 3'b001; b1.CALC_out = 16'h0700; b1.CALC_done = 1'b1;   // t
    step();                                                          // t+1
    b1.CALC_done = 1'b0;
    chk("rmid_memrd_t1", 16'(b1.MEM_rd), 16'h1);
    step();                                                          // t+2
    rst = 1'b1;
    #1;
    chk("rmid_src", b1.SRC_op, 16'h0);
    chk("rmid_dstop", b1.DST_op, 16'h0);
    chk("rmid_dstaddr", b1.DST_addr, 16'h0);
    chk("rmid_mab", b1.MAB_out, 16'h0);
    chk("rmid_memrd", 16'(b1.MEM_rd), 16'h0);
    chk("rmid_busy", 16'(b1.busy), 16'h0);
    chk("rmid_ovr", 16'(b1.ovr), 16'h0);
    chk("rmid_opv", 16'(b1.OP_valid), 16'h0);
    step();
    rst = 1'b0;
    step();
    b1.CALC_out = 16'h0208; b1.MDB_out = 16'h1234; b1.CALC_done = 1'b1; // t
    step();                                                          // t+1
    b1.CALC_done = 1'b0;
    chk("rpost_memrd_t1", 16'(b1.MEM_rd), 16'h1);
    chk("rpost_mab_t1", b1.MAB_out, 16'h0208);
    step();                                                          // t+2
    step();                                                          // t+3
    chk("rpost_opv_t3", 16'(b1.OP_valid), 16'h1);
    chk("rpost_src_t3", b1.SRC_op, 16'h1234);
    step();

    // Non-indexed mode: pulse is ignored
    b1.AdAs = 3'b010; b1.CALC_out = 16'h0888; b1.CALC_done = 1'b1;   // t
    step();                                                          // t+1
    b1.CALC_done = 1'b0;
    chk("nidx_memrd_t1", 16'(b1.MEM_rd), 16'h0);
    chk("nidx_busy_t1", 16'(b1.busy), 16'h0);
    step();                                                          // t+2
    chk("nidx_memrd_t2", 16'(b1.MEM_rd), 16'h0);
    chk("nidx_busy_t2", 16'(b1.busy), 16'h0);
    chk("nidx_ovr_t2", 16'(b1.ovr), 16'h0);
    chk("nidx_mabhold", b1.MAB_out, 16'h0208);

    // Pulse in the DONE cycle starts the next operation
    b1.AdAs = 3'b001; b1.CALC_out = 16'h0A00; b1.MDB_out = 16'hAAAA; b1.CALC_done = 1'b1;
    step();                                                          // t+1
    b1.CALC_done = 1'b0;
    step();                                                          // t+2
    step();                                                          // t+3
    chk("b2b_opv_t3", 16'(b1.OP_valid), 16'h1);
    chk("b2b_src_t3", b1.SRC_op, 16'hAAAA);
    b1.CALC_out = 16'h0B00; b1.CALC_done = 1'b1;
    step();                                                          // t+4
    b1.CALC_done = 1'b0; b1.MDB_out = 16'hBBBB;
    chk("b2b_memrd_t4", 16'(b1.MEM_rd), 16'h1);
    chk("b2b_mab_t4", b1.MAB_out, 16'h0B00);
    chk("b2b_busy_t4", 16'(b1.busy), 16'h1);
    chk("b2b_ovr_t4", 16'(b1.ovr), 16'h0);
    step();                                                          // t+5
    step();                                                          // t+6
    chk("b2b_opv_t6", 16'(b1.OP_valid), 16'h1);
    chk("b2b_src_t6", b1.SRC_op, 16'hBBBB);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
